drfm_delay_line: RTL and testbench

Programmable sample-delay stage for the DRFM replay path. It sits directly downstream of the scaling stream pipeline and consumes its 32-bit valid/ready stream. It writes every accepted sample into a circular buffer and emits, for each accepted input, the sample accepted `delay` samples earlier, or zero while the line is still filling. It is the range-delay element that the false-target generator retunes on the fly.

---
 rtl/drfm_delay_line_if.sv | 26 ++
 rtl/drfm_delay_line.sv | 115 +++++++++++
 tb/tb_drfm_delay_line.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drfm_delay_line_if.sv
// Sample stream bundle for the DRFM delay line.
//   in_valid/in_ready/in_data    : upstream 32-bit valid/ready stream into the block
//   out_valid/out_ready/out_data : delayed stream towards the downstream stage
// Modports:
//   master : the side that sources input samples and sinks output samples
//   slave  : the delay line itself
interface drfm_delay_line_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/drfm_delay_line.sv
// Programmable sample-delay stage for the DRFM replay path.
// Every accepted sample is written into a circular buffer; for each accepted
// input the block emits the sample accepted delay_active samples earlier, or
// zero while the line is still filling after a (re)load of the delay.
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : level; low forces IDLE, rising edge loads cfg_delay
//   cfg_load     : one-cycle pulse, reloads cfg_delay while FILL/RUN
//   cfg_delay    : requested delay in samples (0 .. 2**AW-1)
//   strm         : input/output sample streams (slave modport)
//   state_o      : 0=IDLE, 1=FILL, 2=RUN
//   delay_active : currently latched delay
module drfm_delay_line #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [AW-1:0]     cfg_delay,
  drfm_delay_line_if.slave  strm,
  output logic [1:0]        state_o,
  output logic [AW-1:0]     delay_active
);
  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_delay, w_next_delay;
  logic [AW-1:0] r_fill_cnt, w_next_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_rd_addr;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] w_out_sample;
  logic          w_in_ready;
  logic          w_accept;
  logic [DW-1:0] r_mem [DEPTH];

  assign w_in_ready = (r_state != S_IDLE) && (!r_out_valid || strm.out_ready);
  assign w_accept   = strm.in_valid && w_in_ready;
  // Modulo-2^AW subtraction; the read happens before this cycle's write.
  assign w_rd_addr  = r_wr_ptr - r_delay;

  assign strm.in_ready  = w_in_ready;
  assign strm.out_valid = r_out_valid;
  assign strm.out_data  = r_out_data;
  assign state_o        = r_state;
  assign delay_active   = r_delay;

  // Priority: enable low > load (enable rise or cfg_load) > FILL countdown.
  // A sample accepted alongside cfg_load is still processed under the old
  // state/delay, so the countdown branch is simply skipped in that cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_delay = r_delay;
    w_next_cnt   = r_fill_cnt;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else if (r_state == S_IDLE || cfg_load) begin
      w_next_delay = cfg_delay;
      w_next_cnt   = cfg_delay;
      w_next_state = (cfg_delay == '0) ? S_RUN : S_FILL;
    end else if (r_state == S_FILL && w_accept) begin
      w_next_cnt = r_fill_cnt - AW'(1);
      if (r_fill_cnt == AW'(1)) w_next_state = S_RUN;
    end
  end

  // Zero during FILL; zero delay bypasses the buffer entirely.
  always_comb begin
    w_out_sample = '0;
    if (r_state == S_RUN) begin
      w_out_sample = (r_delay == '0) ? strm.in_data : r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_delay    <= '0;
      r_fill_cnt <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_delay    <= w_next_delay;
      r_fill_cnt <= w_next_cnt;
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_out_sample;
    end else if (strm.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= strm.in_data;
  end
endmodule

// File: tb/tb_drfm_delay_line.sv
module tb_drfm_delay_line;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          cfg_load;
  logic [AW-1:0] cfg_delay;
  logic [1:0]    state_o;
  logic [AW-1:0] delay_active;

  drfm_delay_line_if #(.DW(DW)) bus ();

  drfm_delay_line #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_load     (cfg_load),
    .cfg_delay    (cfg_delay),
    .strm         (bus),
    .state_o      (state_o),
    .delay_active (delay_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: full history of accepted samples, plus the number of
  // samples accepted since the current delay was loaded.
  logic [DW-1:0] hist[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   m_delay = 0;
  int unsigned   m_epoch = 0;

  function automatic void model_load(input int unsigned d);
    m_delay = d;
    m_epoch = 0;
  endfunction

  function automatic void model_accept(input logic [DW-1:0] d);
    hist.push_back(d);
    if (m_epoch < m_delay) exp_q.push_back('0);
    else exp_q.push_back(hist[hist.size() - 1 - m_delay]);
    m_epoch++;
  endfunction

  // One clock cycle: called at posedge+2, drives the stream, observes at
  // posedge+8, updates the model, returns at the next posedge+2.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                       output logic acc, output logic fired,
                       output logic [DW-1:0] got, output logic [DW-1:0] want,
                       output logic ov, output logic ir);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #6;
    ov    = bus.out_valid;
    ir    = bus.in_ready;
    got   = bus.out_data;
    acc   = v && ir;
    fired = ov && r;
    want  = 'x;
    if (fired && exp_q.size() > 0) want = exp_q.pop_front();
    if (acc) model_accept(d);
    @(posedge clk);
    #2;
  endtask

  task automatic drain_and_check(input string tag);
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want;
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) begin
      cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
      if (fired) begin
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s_drain data: got %h expected %h", tag, got, want);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain outstanding: got %0d expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_extra_output out_valid: got %b expected 0", tag, ov);
    end
  endtask

  task automatic reenable(input logic [AW-1:0] d);
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want;
    enable = 1'b0;
    cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
    cfg_delay = d;
    enable    = 1'b1;
    cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
    model_load(d);
  endtask

  task automatic test_reset;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want;
    rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; cfg_delay = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_cmp++; if (delay_active !== '0) begin n_bad++; $display("FAIL reset_delay: got %0d expected 0", delay_active); end
    rst_n = 1'b1;
    cycle(1'b1, 32'h1234, 1'b1, acc, fired, got, want, ov, ir);
    n_cmp++; if (acc !== 1'b0) begin n_bad++; $display("FAIL idle_no_accept: got %b expected 0", acc); end
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL idle_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_basic;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want;
    int acc_cnt = 0;
    int n_out = 0;
    logic [1:0] exp_state;
    cfg_delay = 4'd3;
    enable    = 1'b1;
    cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
    model_load(3);
    n_cmp++; if (delay_active !== 4'd3) begin n_bad++; $display("FAIL basic_delay_latch: got %0d expected 3", delay_active); end
    for (int g = 0; g < 40 && acc_cnt < 10; g++) begin
      exp_state = (acc_cnt >= 3) ? 2'd2 : 2'd1;
      n_cmp++;
      if (state_o !== exp_state) begin n_bad++; $display("FAIL basic_state after %0d accepts: got %0d expected %0d", acc_cnt, state_o, exp_state); end
      cycle(1'b1, DW'(acc_cnt + 1), 1'b1, acc, fired, got, want, ov, ir);
      if (fired) begin
        n_out++;
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL basic_data: got %h expected %h", got, want); end
      end
      if (acc) acc_cnt++;
    end
    n_cmp++; if (acc_cnt != 10) begin n_bad++; $display("FAIL basic_accepts: got %0d expected 10", acc_cnt); end
    drain_and_check("basic");
  endtask

  task automatic test_zero_delay;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want, d;
    reenable('0);
    n_cmp++; if (state_o !== 2'd2) begin n_bad++; $display("FAIL zero_state: got %0d expected 2", state_o); end
    for (int i = 0; i < 8; i++) begin
      d = $urandom | 32'h1;
      cycle(1'b1, d, 1'b1, acc, fired, got, want, ov, ir);
      n_cmp++;
      if (ir !== 1'b1) begin n_bad++; $display("FAIL zero_throughput in_ready: got %b expected 1", ir); end
      if (i > 0) begin
        n_cmp++;
        if (fired !== 1'b1) begin n_bad++; $display("FAIL zero_latency out_valid: got %b expected 1", fired); end
      end
      if (fired) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL zero_data: got %h expected %h", got, want); end
      end
    end
    drain_and_check("zero");
  endtask

  task automatic test_wrap;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want, formula;
    int k = 0;
    int idx = 0;
    reenable(4'd15);
    n_cmp++; if (state_o !== 2'd1) begin n_bad++; $display("FAIL wrap_state: got %0d expected 1", state_o); end
    for (int g = 0; g < 80 && k < 40; g++) begin
      cycle(1'b1, DW'(k), 1'b1, acc, fired, got, want, ov, ir);
      if (fired) begin
        formula = (idx >= 15) ? DW'(idx - 15) : '0;
        n_cmp++;
        if (got !== formula) begin n_bad++; $display("FAIL wrap_data out %0d: got %h expected %h", idx, got, formula); end
        idx++;
      end
      if (acc) k++;
    end
    drain_and_check("wrap");
  endtask

  task automatic test_backpressure;
    logic acc, fired, ov, ir, v, r;
    logic [DW-1:0] got, want, held;
    logic stalled = 1'b0;
    int acc_cnt = 0;
    cfg_delay = 4'd2;
    cfg_load  = 1'b1;
    cycle(1'b0, '0, 1'b1, acc, fired, got, want, ov, ir);
    cfg_load = 1'b0;
    model_load(2);
    n_cmp++; if (state_o !== 2'd1 || delay_active !== 4'd2) begin n_bad++; $display("FAIL bp_load state/delay: got %0d/%0d expected 1/2", state_o, delay_active); end
    held = '0;
    for (int g = 0; g < 400 && acc_cnt < 40; g++) begin
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 1) == 1;
      cycle(v, $urandom, r, acc, fired, got, want, ov, ir);
      if (stalled) begin
        n_cmp++;
        if (ov !== 1'b1 || got !== held) begin n_bad++; $display("FAIL bp_hold: got %b/%h expected 1/%h", ov, got, held); end
      end
      if (ov && !r) begin
        n_cmp++;
        if (ir !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", ir); end
      end
      if (fired) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL bp_data: got %h expected %h", got, want); end
      end
      stalled = ov && !r;
      held    = got;
      if (acc) acc_cnt++;
    end
    n_cmp++; if (acc_cnt != 40) begin n_bad++; $display("FAIL bp_accepts: got %0d expected 40", acc_cnt); end
    drain_and_check("bp");
  endtask

  task automatic test_reconfig;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want;
    for (int i = 11; i < 20; i++) begin
      cycle(1'b1, DW'(i), 1'b1, acc, fired, got, want, ov, ir);
      if (fired) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reconf_pre_data: got %h expected %h", got, want); end
      end
    end
    cfg_delay = 4'd5;
    cfg_load  = 1'b1;
    cycle(1'b1, 32'd20, 1'b1, acc, fired, got, want, ov, ir);
    cfg_load = 1'b0;
    model_load(5);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL reconf_accept20: got %b expected 1", acc); end
    if (fired) begin
      n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL reconf_load_cycle_data: got %h expected %h", got, want); end
    end
    n_cmp++; if (state_o !== 2'd1 || delay_active !== 4'd5) begin n_bad++; $display("FAIL reconf_state/delay: got %0d/%0d expected 1/5", state_o, delay_active); end
    for (int i = 21; i < 36; i++) begin
      cycle(1'b1, DW'(i), 1'b1, acc, fired, got, want, ov, ir);
      if (i == 21) begin
        n_cmp++;
        if (fired !== 1'b1 || got !== 32'd18) begin n_bad++; $display("FAIL reconf_out20: got %b/%h expected 1/12", fired, got); end
      end
      if (fired) begin
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reconf_data: got %h expected %h", got, want); end
      end
    end
    drain_and_check("reconf");
  endtask

  task automatic test_disable_reset;
    logic acc, fired, ov, ir;
    logic [DW-1:0] got, want, pend;
    cycle(1'b1, 32'hA5A5_0001, 1'b0, acc, fired, got, want, ov, ir);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL dis_accept: got %b expected 1", acc); end
    enable = 1'b0;
    cycle(1'b1, 32'hA5A5_0002, 1'b0, acc, fired, got, want, ov, ir);
    n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL dis_stall_in_ready: got %b expected 0", ir); end
    pend = (exp_q.size() > 0) ? exp_q[0] : 'x;
    cycle(1'b1, 32'hA5A5_0003, 1'b0, acc, fired, got, want, ov, ir);
    n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL dis_state: got %0d expected 0", state_o); end
    n_cmp++; if (ir !== 1'b0) begin n_bad++; $display("FAIL dis_in_ready: got %b expected 0", ir); end
    n_cmp++; if (ov !== 1'b1 || got !== pend) begin n_bad++; $display("FAIL dis_hold: got %b/%h expected 1/%h", ov, got, pend); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL async_rst_in_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (bus.out_data !== '0 || delay_active !== '0) begin n_bad++; $display("FAIL async_rst_data/delay: got %h/%0d expected 0/0", bus.out_data, delay_active); end
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_delay();
    test_wrap();
    test_backpressure();
    test_reconfig();
    test_disable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
